// File: rtl/i2c_target_regs_if.sv
// -----------------------------------------------------------------------------
// i2c_target_regs_if
// Local register-bank port of the I2C target: the side that lets on-chip logic
// exchange values with the remote I2C master.
//
//   loc_addr   local register index
//   loc_wdata  local write data
//   loc_we     local write enable, one cycle per write
//   loc_rdata  regs[loc_addr], combinational
//   wr_strobe  one-cycle pulse after the bus writes a register
//   wr_index   index written by the bus, held until the next strobe
//
// Modports: master = local logic, slave = the I2C target block.
// -----------------------------------------------------------------------------
interface i2c_target_regs_if #(
   parameter int AW = 3
);
   logic [AW-1:0] loc_addr;
   logic [7:0]    loc_wdata;
   logic          loc_we;
   logic [7:0]    loc_rdata;
   logic          wr_strobe;
   logic [AW-1:0] wr_index;

   modport master (
      output loc_addr, loc_wdata, loc_we,
      input  loc_rdata, wr_strobe, wr_index
   );

   modport slave (
      input  loc_addr, loc_wdata, loc_we,
      output loc_rdata, wr_strobe, wr_index
   );
endinterface

// File: rtl/i2c_target_regs.sv
// -----------------------------------------------------------------------------
// i2c_target_regs
// I2C target (responder) with a byte-wide register bank. SCL/SDA are
// oversampled on the system clock; the target never stretches SCL and drives
// SDA open-drain (0 or 'z').
//
// Ports:
//   clock   system clock, >= 16x SCL frequency
//   reset   asynchronous active-low reset
//   scl     bus clock from the master (asynchronous)
//   sda     bus data, open-drain
//   loc     local register-bank port (i2c_target_regs_if.slave)
//   busy    high from an addressed START until STOP
//
// Protocol: write = START, addr+W, ptr, data..., STOP (ptr auto-increments).
//           read  = START, addr+R, data... (from current ptr), NACK, STOP.
// ptr survives STOP and repeated START; only reset clears it.
// -----------------------------------------------------------------------------
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h20,
   parameter int         NUM_REGS = 8,
   parameter int         AW       = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              scl,
   inout  wire               sda,
   i2c_target_regs_if.slave  loc,
   output logic              busy
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } state_t;

   state_t        state_q, state_nxt;

   // Synchroniser (p0, p1) and history (p2) for both bus lines
   logic          scl_p0, scl_p1, scl_p2;
   logic          sda_p0, sda_p1, sda_p2;

   logic          scl_rise, scl_fall, start_det, stop_det;

   logic [3:0]    bit_cnt_q, bit_cnt_nxt;
   logic [7:0]    shreg_q, shreg_nxt;
   logic [AW-1:0] ptr_q, ptr_nxt;
   logic          rw_q, rw_nxt;
   // drv_low: ACK drive; tx: shreg_q[7] owns SDA during a read byte
   logic          drv_low_q, drv_low_nxt;
   logic          tx_q, tx_nxt;
   // ack_on: second-phase marker inside the ACK states
   logic          ack_on_q, ack_on_nxt;
   logic          busy_q, busy_nxt;
   logic          wr_strobe_q, wr_strobe_nxt;
   logic [AW-1:0] wr_index_q, wr_index_nxt;
   logic          bus_we;
   logic          loc_we_ok;
   logic [7:0]    byte_in;
   logic          sda_drive;

   logic [7:0]    regs [NUM_REGS];

   // ---- stage p0..p2: input conditioning ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // Idle bus level, so leaving reset never looks like an edge on SDA
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= sda;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   assign scl_rise  =  scl_p1 & ~scl_p2;
   assign scl_fall  = ~scl_p1 &  scl_p2;
   assign start_det =  scl_p1 &  scl_p2 &  sda_p2 & ~sda_p1;
   assign stop_det  =  scl_p1 &  scl_p2 & ~sda_p2 &  sda_p1;

   // Byte being assembled, including the bit sampled at this rise
   assign byte_in = {shreg_q[6:0], sda_p1};

   // ---- stage FSM: state register ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // ---- stage FSM: next state and datapath controls ----
   always_comb begin
      state_nxt     = state_q;
      bit_cnt_nxt   = bit_cnt_q;
      shreg_nxt     = shreg_q;
      ptr_nxt       = ptr_q;
      rw_nxt        = rw_q;
      drv_low_nxt   = drv_low_q;
      tx_nxt        = tx_q;
      ack_on_nxt    = ack_on_q;
      busy_nxt      = busy_q;
      wr_strobe_nxt = 1'b0;
      wr_index_nxt  = wr_index_q;
      bus_we        = 1'b0;

      if (stop_det) begin
         state_nxt   = IDLE;
         bit_cnt_nxt = 4'd0;
         drv_low_nxt = 1'b0;
         tx_nxt      = 1'b0;
         ack_on_nxt  = 1'b0;
         busy_nxt    = 1'b0;
      end else if (start_det) begin
         // START from IDLE or a repeated START; ptr is deliberately kept
         state_nxt   = ADDR;
         bit_cnt_nxt = 4'd0;
         drv_low_nxt = 1'b0;
         tx_nxt      = 1'b0;
         ack_on_nxt  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
            end

            ADDR: begin
               if (scl_rise) begin
                  shreg_nxt   = byte_in;
                  bit_cnt_nxt = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_nxt = 4'd0;
                     if (byte_in[7:1] == DEV_ADDR) begin
                        state_nxt = ADDR_ACK;
                        busy_nxt  = 1'b1;
                        rw_nxt    = byte_in[0];
                     end else begin
                        state_nxt = IGNORE;
                     end
                  end
               end
            end

            // First fall pulls SDA low for the 9th clock, second fall ends it
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_on_q) begin
                     ack_on_nxt  = 1'b1;
                     drv_low_nxt = 1'b1;
                  end else begin
                     ack_on_nxt  = 1'b0;
                     drv_low_nxt = 1'b0;
                     bit_cnt_nxt = 4'd0;
                     if (state_q == ADDR_ACK && rw_q) begin
                        state_nxt = RDATA;
                        shreg_nxt = regs[ptr_q];
                        tx_nxt    = 1'b1;
                     end else if (state_q == ADDR_ACK) begin
                        state_nxt = PTR;
                     end else begin
                        state_nxt = WDATA;
                     end
                  end
               end
            end

            PTR: begin
               if (scl_rise) begin
                  shreg_nxt   = byte_in;
                  bit_cnt_nxt = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_nxt = 4'd0;
                     ptr_nxt     = byte_in[AW-1:0];
                     state_nxt   = PTR_ACK;
                  end
               end
            end

            WDATA: begin
               if (scl_rise) begin
                  shreg_nxt   = byte_in;
                  bit_cnt_nxt = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_nxt   = 4'd0;
                     bus_we        = 1'b1;
                     wr_strobe_nxt = 1'b1;
                     wr_index_nxt  = ptr_q;
                     ptr_nxt       = ptr_q + AW'(1);
                     state_nxt     = WDATA_ACK;
                  end
               end
            end

            // shreg is a snapshot taken at load; bank writes do not reach it
            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_nxt = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     bit_cnt_nxt = 4'd0;
                     tx_nxt      = 1'b0;
                     ptr_nxt     = ptr_q + AW'(1);
                     state_nxt   = RDATA_ACK;
                  end else if (bit_cnt_q != 4'd0) begin
                     shreg_nxt = {shreg_q[6:0], 1'b0};
                  end
               end
            end

            RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_p1) begin
                     state_nxt = IGNORE;
                  end else begin
                     ack_on_nxt = 1'b1;
                  end
               end else if (scl_fall && ack_on_q) begin
                  ack_on_nxt = 1'b0;
                  shreg_nxt  = regs[ptr_q];
                  tx_nxt     = 1'b1;
                  state_nxt  = RDATA;
               end
            end

            IGNORE: begin
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // ---- stage FSM: control and shift registers ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt_q   <= 4'd0;
         shreg_q     <= 8'h00;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         drv_low_q   <= 1'b0;
         tx_q        <= 1'b0;
         ack_on_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         bit_cnt_q   <= bit_cnt_nxt;
         shreg_q     <= shreg_nxt;
         ptr_q       <= ptr_nxt;
         rw_q        <= rw_nxt;
         drv_low_q   <= drv_low_nxt;
         tx_q        <= tx_nxt;
         ack_on_q    <= ack_on_nxt;
         busy_q      <= busy_nxt;
         wr_strobe_q <= wr_strobe_nxt;
         wr_index_q  <= wr_index_nxt;
      end
   end

   // A bus byte owns its index both on the commit edge and during the strobe
   // cycle, so local logic reacting to wr_strobe cannot overwrite it.
   assign loc_we_ok = loc.loc_we
                    && !(bus_we      && (loc.loc_addr == ptr_q))
                    && !(wr_strobe_q && (loc.loc_addr == wr_index_q));

   // ---- stage bank: register storage ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= 8'h00;
         end
      end else begin
         if (loc_we_ok) begin
            regs[loc.loc_addr] <= loc.loc_wdata;
         end
         if (bus_we) begin
            regs[ptr_q] <= byte_in;
         end
      end
   end

   // ---- stage out: pins and local port ----
   assign sda_drive     = drv_low_q | (tx_q & ~shreg_q[7]);
   assign sda           = sda_drive ? 1'b0 : 1'bz;
   assign busy          = busy_q;
   assign loc.loc_rdata = regs[loc.loc_addr];
   assign loc.wr_strobe = wr_strobe_q;
   assign loc.wr_index  = wr_index_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regs
// Directed bench: a bit-banged I2C master drives the target through writes,
// address mismatch, combined read, local/bus collisions, abort and reset.
// -----------------------------------------------------------------------------
module tb_i2c_target_regs;
   localparam int AW = 3;
   localparam int Q  = 8;   // system clocks per quarter SCL period

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic scl_m = 1'b1;
   logic m_low = 1'b0;
   logic busy;
   wire  sda;

   int checks = 0;
   int errors = 0;

   int            strobe_cnt  = 0;
   int            strobe_wide = 0;
   logic [AW-1:0] strobe_idx [0:15];
   logic          strobe_prev = 1'b0;
   int            dut_low_cnt = 0;
   int            busy_cnt    = 0;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_target_regs_if #(.AW(AW)) loc_if ();

   i2c_target_regs #(.DEV_ADDR(7'h20), .NUM_REGS(8), .AW(AW)) dut (
      .clock (clock),
      .reset (reset),
      .scl   (scl_m),
      .sda   (sda),
      .loc   (loc_if),
      .busy  (busy)
   );

   always #5 clock = ~clock;

   // Master changes pins only on negedges, so posedge sampling is race-free
   always @(posedge clock) begin
      if (loc_if.wr_strobe) begin
         if (strobe_prev) begin
            strobe_wide++;
         end else begin
            if (strobe_cnt < 16) strobe_idx[strobe_cnt] = loc_if.wr_index;
            strobe_cnt++;
         end
      end
      strobe_prev = loc_if.wr_strobe;
      if (!m_low && sda == 1'b0) dut_low_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Works from idle (SCL high) and as a repeated START (SCL low)
   task automatic bus_start();
      m_low = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      m_low = 1'b1; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      m_low = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      m_low = 1'b0; wait_clk(2 * Q);
   endtask

   task automatic send_bit(input logic b);
      m_low = ~b;   wait_clk(Q);
      scl_m = 1'b1; wait_clk(2 * Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_low = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b = sda;      wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic nack);
      logic b;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b);
         d = {d[6:0], b};
      end
      send_bit(nack);
   endtask

   task automatic loc_write(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clock);
      loc_if.loc_addr  = a;
      loc_if.loc_wdata = d;
      loc_if.loc_we    = 1'b1;
      @(negedge clock);
      loc_if.loc_we    = 1'b0;
   endtask

   task automatic loc_read_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
      loc_if.loc_addr = a;
      #1;
      check_eq(tag, {24'h0, loc_if.loc_rdata}, {24'h0, exp});
   endtask

   // Bus writes one byte at ptr while local logic writes in the strobe cycle
   task automatic collide(input logic [AW-1:0] la, input string tag);
      logic a0, a1, a2;
      logic seen;
      seen = 1'b0;
      bus_start();
      send_byte(8'h40, a0);
      send_byte(8'h01, a1);
      fork
         send_byte(8'h11, a2);
         begin
            for (int i = 0; i < 2000 && !seen; i++) begin
               @(negedge clock);
               if (loc_if.wr_strobe) seen = 1'b1;
            end
            if (seen) begin
               loc_if.loc_addr  = la;
               loc_if.loc_wdata = 8'h99;
               loc_if.loc_we    = 1'b1;
               @(negedge clock);
               loc_if.loc_we    = 1'b0;
            end
         end
      join
      bus_stop();
      check_eq({tag, "_strobe_seen"}, {31'h0, seen}, 32'd1);
      check_eq({tag, "_ack"}, {29'h0, a0, a1, a2}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic a0, a1, a2, a3, b;
      logic [7:0] rd;
      int sc0, dl0, bc0;

      loc_if.loc_addr  = '0;
      loc_if.loc_wdata = 8'h00;
      loc_if.loc_we    = 1'b0;
      wait_clk(4);

      // Reset state
      check_eq("rst_sda", {31'h0, sda}, 32'd1);
      check_eq("rst_busy", {31'h0, busy}, 32'd0);
      check_eq("rst_strobe", {31'h0, loc_if.wr_strobe}, 32'd0);
      check_eq("rst_index", {29'h0, loc_if.wr_index}, 32'd0);
      loc_read_chk("rst_reg0", 3'd0, 8'h00);
      @(negedge clock);
      reset = 1'b1;
      wait_clk(4);

      // Addressed write with ptr wrap 7 -> 0
      bus_start();
      send_byte(8'h40, a0);
      check_eq("w_busy_mid", {31'h0, busy}, 32'd1);
      send_byte(8'h07, a1);
      send_byte(8'hA5, a2);
      send_byte(8'h3C, a3);
      bus_stop();
      check_eq("w_acks", {28'h0, a0, a1, a2, a3}, 32'd0);
      check_eq("w_busy_end", {31'h0, busy}, 32'd0);
      loc_read_chk("w_reg7", 3'd7, 8'hA5);
      loc_read_chk("w_reg0", 3'd0, 8'h3C);
      check_eq("w_strobes", strobe_cnt, 32'd2);
      check_eq("w_idx0", {29'h0, strobe_idx[0]}, 32'd7);
      check_eq("w_idx1", {29'h0, strobe_idx[1]}, 32'd0);

      // Address mismatch
      sc0 = strobe_cnt; dl0 = dut_low_cnt; bc0 = busy_cnt;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h11, a1);
      bus_stop();
      check_eq("mm_nacks", {30'h0, a0, a1}, 32'd3);
      check_eq("mm_sda_low", dut_low_cnt - dl0, 32'd0);
      check_eq("mm_strobes", strobe_cnt - sc0, 32'd0);
      check_eq("mm_busy", busy_cnt - bc0, 32'd0);
      loc_read_chk("mm_reg1", 3'd1, 8'h00);
      loc_read_chk("mm_reg7", 3'd7, 8'hA5);

      // Combined write-ptr / repeated-START read
      loc_write(3'd2, 8'h5A);
      loc_write(3'd3, 8'hC3);
      loc_write(3'd4, 8'h77);
      bus_start();
      send_byte(8'h40, a0);
      send_byte(8'h02, a1);
      bus_start();
      send_byte(8'h41, a2);
      recv_byte(rd, 1'b0);
      check_eq("rd_byte0", {24'h0, rd}, 32'h5A);
      recv_byte(rd, 1'b1);
      check_eq("rd_byte1", {24'h0, rd}, 32'hC3);
      bus_stop();
      check_eq("rd_acks", {29'h0, a0, a1, a2}, 32'd0);
      // ptr is expected at 4: a fresh read must return regs[4]
      bus_start();
      send_byte(8'h41, a0);
      recv_byte(rd, 1'b1);
      bus_stop();
      check_eq("rd_ptr4", {24'h0, rd}, 32'h77);

      // Collision on the same index, then on a different index
      collide(3'd1, "coll_same");
      loc_read_chk("coll_same_reg1", 3'd1, 8'h11);
      loc_write(3'd1, 8'h00);
      collide(3'd2, "coll_diff");
      loc_read_chk("coll_diff_reg1", 3'd1, 8'h11);
      loc_read_chk("coll_diff_reg2", 3'd2, 8'h99);
      check_eq("coll_idx", {26'h0, strobe_idx[2], strobe_idx[3]}, {26'h0, 3'd1, 3'd1});

      // STOP after 4 data bits: no write
      sc0 = strobe_cnt;
      bus_start();
      send_byte(8'h40, a0);
      send_byte(8'h06, a1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      bus_stop();
      check_eq("ab_strobes", strobe_cnt - sc0, 32'd0);
      check_eq("ab_busy", {31'h0, busy}, 32'd0);
      loc_read_chk("ab_reg6", 3'd6, 8'h00);
      // Block is back in IDLE and ptr is still 6
      loc_write(3'd6, 8'h81);
      bus_start();
      send_byte(8'h41, a0);
      recv_byte(rd, 1'b1);
      bus_stop();
      check_eq("ab_read6", {24'h0, rd}, 32'h81);

      // Reset in the middle of reading regs[7]=0xA5
      bus_start();
      send_byte(8'h41, a0);
      recv_bit(b);
      check_eq("rr_bit7", {31'h0, b}, 32'd1);
      check_eq("rr_pre_low", {31'h0, sda}, 32'd0);
      reset = 1'b0;
      #1;
      check_eq("rr_sda_rel", {31'h0, sda}, 32'd1);
      check_eq("rr_busy", {31'h0, busy}, 32'd0);
      check_eq("rr_strobe", {31'h0, loc_if.wr_strobe}, 32'd0);
      check_eq("rr_index", {29'h0, loc_if.wr_index}, 32'd0);
      loc_read_chk("rr_reg7", 3'd7, 8'h00);
      @(negedge clock);
      reset = 1'b1;
      wait_clk(4);
      bus_stop();
      sc0 = strobe_cnt;
      bus_start();
      send_byte(8'h40, a0);
      send_byte(8'h03, a1);
      send_byte(8'h6E, a2);
      bus_stop();
      check_eq("rr_w_acks", {29'h0, a0, a1, a2}, 32'd0);
      check_eq("rr_w_strobe", strobe_cnt - sc0, 32'd1);
      check_eq("rr_w_idx", {29'h0, strobe_idx[4]}, 32'd3);
      loc_read_chk("rr_reg3", 3'd3, 8'h6E);
      bus_start();
      send_byte(8'h40, a0);
      send_byte(8'h03, a1);
      bus_start();
      send_byte(8'h41, a2);
      recv_byte(rd, 1'b1);
      bus_stop();
      check_eq("rr_r_acks", {29'h0, a0, a1, a2}, 32'd0);
      check_eq("rr_r_data", {24'h0, rd}, 32'h6E);

      check_eq("strobe_width", strobe_wide, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
